player_iter: RTL and testbench
==============================

Name: player_iter

Overview:
- Iterative, parametrised PRESENT-style bit-permutation engine; next generation of the fixed 64-bit P-layer.
- Supports:
  - any width that is a multiple of 4;
  - forward and inverse mode;
  - 0..MAX_ROUNDS back-to-back permutation passes, one pass per clock.
- Valid/ready handshake on both sides, so it drops into the cipher datapath between the S-box layer and key addition, and into the permutation self-test harness.

Parameters:
- WIDTH, 64, block width in bits; must be a multiple of 4 and at least 8.
- MAX_ROUNDS, 31, largest round count accepted; larger requests are clamped to this value.
- RW, $clog2(MAX_ROUNDS+1), width of the round-count field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction offered.
- in_ready  out  1  engine can accept this cycle.
- in_data  in  WIDTH  block to permute.
- in_inverse  in  1  0 = forward P-layer, 1 = inverse P-layer.
- in_rounds  in  RW  number of passes to apply.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  permuted block.

Behaviour:
- Permutation definition, with Q = WIDTH/4:
  - P(i) = (i*Q) mod (WIDTH-1) for i < WIDTH-1; P(WIDTH-1) = WIDTH-1.
  - Forward: y[P(i)] = x[i].
  - Inverse: y[i] = x[P(i)], equivalently y[(4*j) mod (WIDTH-1) source mapping].
  - WIDTH=64 reproduces the existing PBox exactly.
- States: IDLE, BUSY, DONE.
- Reset (rst=1 at an edge):
  - state goes to IDLE; data register, count and mode clear to 0.
  - out_valid=0, out_data=0; in_ready=1 from the next cycle.
  - Reset overrides any in-flight transaction, which is discarded without output.
- Outputs are combinational functions of state:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - out_valid = (state==DONE).
  - out_data = data register.
- Accept: in_valid && in_ready at an edge. At that edge:
  - data <= in_data.
  - mode <= in_inverse.
  - cnt <= min(in_rounds, MAX_ROUNDS).
  - Next state is BUSY if the clamped count > 0, else DONE.
- BUSY, each edge:
  - data <= perm(data, mode); cnt <= cnt-1.
  - When cnt==1, next state is DONE.
- DONE:
  - Holds data until out_valid && out_ready.
  - If in_valid is also high in the same cycle, the new transaction is accepted at that edge (back-to-back, no bubble).
  - Otherwise the engine returns to IDLE.
- Latency: a transaction accepted at edge T0 with R clamped rounds shows out_valid in the cycle after edge T0+R. R=0 is a one-cycle registered pass-through.
- Throughput: one transaction per R+1 cycles with continuous streaming.
- in_data, in_inverse and in_rounds are ignored while in_ready=0.
- Mode and count are latched at accept; changes during BUSY have no effect.
- out_data is stable while out_valid=1 and out_ready=0 (no drop, no change).
- in_rounds > MAX_ROUNDS is clamped silently; no error flag.

Decomposition:
- Shared package present_pkg:
  - state enum (IDLE/BUSY/DONE);
  - constant function pbox_idx(i, width) returning P(i);
  - the WIDTH%4 legality check, enforced via an elaboration-time assertion in player_iter.
- Sub-module player_comb:
  - purely combinational; parameter WIDTH; ports x, inverse, y;
  - built with a generate loop over pbox_idx.
- player_iter instantiates one player_comb on its data register and owns the FSM and handshake.

Test Plan:
- WIDTH=64, forward, rounds=1, in_data=64'h0000_0000_0000_0002 -> out_data=64'h0000_0000_0001_0000, out_valid in the cycle after edge T0+1.
- WIDTH=64, forward, rounds=3, in_data=64'hDEAD_BEEF_0123_4567 -> out_data equals the input (P has order 3); then inverse, rounds=1, on 64'h0000_0000_0001_0000 -> 64'h0000_0000_0000_0002.
- rounds=0, in_data=64'hA5A5_0000_FFFF_1234 -> same value on out_data one cycle after accept; rounds=40 with MAX_ROUNDS=31 -> behaves as 31 rounds, out_valid after edge T0+31.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data and out_valid are stable and in_ready=0; release out_ready with in_valid=1 -> second transaction accepted on the same edge, with no idle cycle between them.
- Assert rst during BUSY (rounds=10, at cycle 4) -> next cycle out_valid=0, out_data=0, in_ready=1, and no result is ever emitted for the aborted transaction.
- WIDTH=16, forward, rounds=1, in_data=16'h0002 -> 16'h0010 (P(1)=4); compare against a golden model over 1000 random (data, mode, rounds) triples.

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-style bit-permutation engines.
package present_pkg;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Destination bit of source bit i for the generalised P-layer (Q = width/4).
  function automatic int unsigned pbox_idx(input int unsigned i, input int unsigned width);
    if (i == width - 1) begin
      return width - 1;
    end
    return (i * (width / 4)) % (width - 1);
  endfunction

  // Widths the permutation is defined for.
  function automatic bit width_ok(input int unsigned width);
    return ((width % 4) == 0) && (width >= 8);
  endfunction

endpackage

// File: rtl/player_comb.sv
// Combinational forward/inverse P-layer for any WIDTH that is a multiple of 4.
module player_comb
  import present_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic             inverse,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_fwd;
  logic [WIDTH-1:0] y_inv;

  // Pure wiring: forward scatters bit i to P(i), inverse gathers it back.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    localparam int unsigned P = pbox_idx(gi, WIDTH);
    assign y_fwd[P]  = x[gi];
    assign y_inv[gi] = x[P];
  end

  assign y = inverse ? y_inv : y_fwd;

endmodule

// File: rtl/player_iter.sv
// Iterative P-layer engine: applies 0..MAX_ROUNDS passes, one per clock, behind
// valid/ready handshakes on both sides.
module player_iter
  import present_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned MAX_ROUNDS = 31,
  parameter int unsigned RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inverse,
  input  logic [RW-1:0]    in_rounds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUSY = ST_BUSY;
  localparam logic [1:0] DONE = ST_DONE;

  // Reject widths the permutation is not defined for.
  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("player_iter: WIDTH must be a multiple of 4 and at least 8");
  end

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] data, data_n;
  logic [RW-1:0]    cnt, cnt_n;
  logic             mode, mode_n;
  logic [WIDTH-1:0] perm_y;
  logic [RW-1:0]    rounds_clamped;
  logic             accept;

  player_comb #(.WIDTH(WIDTH)) u_perm (
    .x       (data),
    .inverse (mode),
    .y       (perm_y)
  );

  // Handshake status derived from state only (plus out_ready for back-to-back accept).
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign out_data  = data;
  assign accept    = in_valid && in_ready;

  // Oversized round requests saturate at MAX_ROUNDS.
  assign rounds_clamped = (in_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : in_rounds;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_n;
      data  <= data_n;
      cnt   <= cnt_n;
      mode  <= mode_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    data_n  = data;
    cnt_n   = cnt;
    mode_n  = mode;
    case (state)
      IDLE: begin
        if (accept) begin
          data_n  = in_data;
          mode_n  = in_inverse;
          cnt_n   = rounds_clamped;
          state_n = (rounds_clamped != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        data_n = perm_y;
        cnt_n  = cnt - RW'(1);
        if (cnt == RW'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          data_n  = in_data;
          mode_n  = in_inverse;
          cnt_n   = rounds_clamped;
          state_n = (rounds_clamped != '0) ? BUSY : DONE;
        end else if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_player_iter.sv
// Directed and randomised checks of player_iter at WIDTH=64 and WIDTH=16.
module tb_player_iter;

  logic clk;
  logic rst;

  // 64-bit instance; RW widened so that rounds > MAX_ROUNDS can be requested.
  logic        a_in_valid, a_in_ready, a_in_inverse, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [5:0]  a_in_rounds;

  // 16-bit instance with a small round limit so clamping is hit often.
  logic        b_in_valid, b_in_ready, b_in_inverse, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [2:0]  b_in_rounds;

  int compared;
  int mismatched;

  player_iter #(.WIDTH(64), .MAX_ROUNDS(31), .RW(6)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_data    (a_in_data),
    .in_inverse (a_in_inverse),
    .in_rounds  (a_in_rounds),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_data   (a_out_data)
  );

  player_iter #(.WIDTH(16), .MAX_ROUNDS(5), .RW(3)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .in_inverse (b_in_inverse),
    .in_rounds  (b_in_rounds),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_data   (b_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Golden P-layer straight from the definition: y[P(i)] = x[i] (forward).
  function automatic logic [63:0] model_perm(input logic [63:0] x, input bit inv, input int w);
    logic [63:0] y;
    int p;
    y = '0;
    for (int i = 0; i < w; i++) begin
      p = (i == w - 1) ? i : (i * (w / 4)) % (w - 1);
      if (inv) y[i] = x[p];
      else     y[p] = x[i];
    end
    return y;
  endfunction

  // Offer one transaction to the 64-bit engine; check latency and result.
  task automatic run_a(input string tag, input logic [63:0] data, input logic inv,
                       input logic [5:0] rounds, input logic [63:0] exp, input int exp_lat);
    int k;
    @(negedge clk);
    a_in_valid   = 1'b1;
    a_in_data    = data;
    a_in_inverse = inv;
    a_in_rounds  = rounds;
    #1 chk({tag, "_inrdy"}, 64'(a_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = ~data;
    k = 0;
    while (!a_out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
    chk({tag, "_data"}, a_out_data, exp);
  endtask

  // Same for the 16-bit engine.
  task automatic run_b(input string tag, input logic [15:0] data, input logic inv,
                       input logic [2:0] rounds, input logic [15:0] exp, input int exp_lat);
    int k;
    @(negedge clk);
    b_in_valid   = 1'b1;
    b_in_data    = data;
    b_in_inverse = inv;
    b_in_rounds  = rounds;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    k = 0;
    while (!b_out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
    chk({tag, "_data"}, 64'(b_out_data), 64'(exp));
  endtask

  initial begin
    int seen;
    int eff;
    logic [15:0] rd;
    logic        ri;
    logic [2:0]  rr;
    logic [63:0] ex;

    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_inverse = 1'b0; a_in_rounds = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_inverse = 1'b0; b_in_rounds = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_data",  a_out_data,       64'd0);
    chk("rst_a_ready", 64'(a_in_ready),  64'd1);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_ready", 64'(b_in_ready),  64'd1);

    // Directed 64-bit vectors
    run_a("fwd1",   64'h0000_0000_0000_0002, 1'b0, 6'd1,  64'h0000_0000_0001_0000, 1);
    run_a("fwd3",   64'hDEAD_BEEF_0123_4567, 1'b0, 6'd3,  64'hDEAD_BEEF_0123_4567, 3);
    run_a("inv1",   64'h0000_0000_0001_0000, 1'b1, 6'd1,  64'h0000_0000_0000_0002, 1);
    run_a("nib",    64'h0000_0000_0000_000F, 1'b0, 6'd1,  64'h0001_0001_0001_0001, 1);
    run_a("nibinv", 64'h0001_0001_0001_0001, 1'b1, 6'd1,  64'h0000_0000_0000_000F, 1);
    run_a("edge",   64'h8000_0000_0000_0001, 1'b0, 6'd1,  64'h8000_0000_0000_0001, 1);
    run_a("r0",     64'hA5A5_0000_FFFF_1234, 1'b0, 6'd0,  64'hA5A5_0000_FFFF_1234, 0);
    // 40 clamps to 31 rounds = 10 full cycles of order 3 plus one pass
    run_a("clamp",  64'h0000_0000_0000_0002, 1'b0, 6'd40, 64'h0000_0000_0001_0000, 31);

    // Backpressure: result held while out_ready is low, then back-to-back accept
    @(negedge clk);
    a_out_ready = 1'b0;
    run_a("bp", 64'h0000_0000_0000_0002, 1'b0, 6'd2, 64'h0000_0000_0000_0010, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
      chk("bp_hold_data",  a_out_data,       64'h0000_0000_0000_0010);
      chk("bp_hold_rdy",   64'(a_in_ready),  64'd0);
    end
    a_in_valid   = 1'b1;
    a_in_data    = 64'h0000_0000_0000_000F;
    a_in_inverse = 1'b0;
    a_in_rounds  = 6'd1;
    a_out_ready  = 1'b1;
    #1 chk("b2b_rdy", 64'(a_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("b2b_busy", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    chk("b2b_valid", 64'(a_out_valid), 64'd1);
    chk("b2b_data",  a_out_data,       64'h0001_0001_0001_0001);

    // Reset during BUSY discards the transaction
    @(negedge clk);
    a_in_valid   = 1'b1;
    a_in_data    = 64'h1234_5678_9ABC_DEF0;
    a_in_inverse = 1'b0;
    a_in_rounds  = 6'd10;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 64'(a_out_valid), 64'd0);
    chk("abort_data",  a_out_data,       64'd0);
    chk("abort_rdy",   64'(a_in_ready),  64'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    chk("abort_no_out", 64'(seen), 64'd0);

    // 16-bit directed and random against the golden model
    run_b("w16_fwd1", 16'h0002, 1'b0, 3'd1, 16'h0010, 1);
    for (int n = 0; n < 1000; n++) begin
      rd  = 16'($urandom);
      ri  = 1'($urandom_range(0, 1));
      rr  = 3'($urandom_range(0, 7));
      eff = (rr > 3'd5) ? 5 : int'(rr);
      ex  = {48'd0, rd};
      for (int j = 0; j < eff; j++) ex = model_perm(ex, ri, 16);
      run_b("w16_rand", rd, ri, rr, ex[15:0], eff);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
